seq_pattern_gen: RTL
====================

# seq_pattern_gen

Serial bit-pattern generator that drives a single-bit stream, one bit per clock, into the team's Moore-style sequence recognizers. A host loads a pattern, length, repeat count and inter-frame gap, pulses `start`, and the block shifts the pattern out MSB-first with a `busy`/`done` handshake. It serves as the transmit end of the single-bit sequence interface, in benches and in self-test paths.

## Interface
- `PAT_W`, 8: maximum pattern length in bits.
- `LEN_W`, `$clog2(PAT_W+1)`: width of `len`.
- `REP_W`, 4: width of `reps`.
- `GAP_W`, 4: width of `gap`.
---
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `abort` in 1: cancel the transfer in progress.
- `pattern` in PAT_W: bits to send; `pattern[len-1]` is sent first.
- `len` in LEN_W: pattern length; values above PAT_W are clamped to PAT_W.
- `reps` in REP_W: additional repetitions; total frames = `reps`+1.
- `gap` in GAP_W: idle cycles between frames; no gap is inserted after the last frame.
- `x_out` out 1: serial data; 0 when not valid.
- `x_valid` out 1: `x_out` carries a pattern bit.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at normal completion.

## Operation
- Moore FSM. States: IDLE, SEND, GAP, DONE. All outputs decode from registered state, bit index and shift register only.
- Reset: next edge goes to IDLE, clears all counters, and forces `x_out`=`x_valid`=`busy`=`done`=0. Reset applies in any state, including mid-transfer.
- **IDLE**, with `start`=1 at an edge:
  - Latch `pattern`, clamped `len`, `reps`, `gap`.
  - If `len`≠0, go to SEND with bit index = `len`-1.
  - If `len`=0, go to DONE. No bits are sent.
- **SEND**: `x_valid`=1, `busy`=1, `x_out`=`pat_reg[idx]`. Index decrements each cycle. After index 0:
  - If the remaining repeat count is 0, go to DONE.
  - Else decrement the repeat count. If `gap`≠0, go to GAP; otherwise go straight back to SEND with index reloaded to `len`-1, so frames are back-to-back.
- **GAP**: `x_valid`=0, `x_out`=0, `busy`=1 for exactly `gap` cycles, then SEND with index reloaded.
- **DONE**: `done`=1, `busy`=0 for one cycle, then IDLE.
- `start` is ignored outside IDLE. Latched fields are not affected by input changes during a transfer.
- `abort`=1 in SEND or GAP: next state is IDLE, no `done` pulse. `abort` in IDLE or DONE has no effect. If `start` and `abort` are both high in IDLE, `start` wins.
- Counters never wrap: the index stops at 0, the repeat count stops at 0, and the gap counter is reloaded on each GAP entry.

## Timing
- Cycle n is the interval after rising edge n.
- `start` is sampled at edge k. Bit j of frame f (f from 0) is on `x_out` in cycle k + f·(L+`gap`) + j, where L is the frame length in bits.
- `done`=1 in cycle k+T, with T = L·(`reps`+1) + `gap`·`reps`. When `len`=0, T=0.
- Earliest next `start` is sampled at edge k+T+1. Sustained throughput is 1 bit/clk.
- `abort` sampled at edge a: outputs are idle in cycle a.

## Configuration
- `SEQ_GEN_PARITY_EN` defined:
  - Each frame is followed by one even-parity bit (XOR of the frame's `len` bits) with `x_valid`=1.
  - Frame length L = `len`+1 for all timing formulas.
  - With `len`=0, still no bits are sent.
- `SEQ_GEN_PARITY_EN` undefined: no parity bit, L = `len`. Parity logic is absent from the netlist.

## Test plan
- `pattern`=8'h0A, `len`=4, `reps`=0, `gap`=0, `start` at edge 10 → `x_out`=1,0,1,0 in cycles 10–13 with `x_valid`=1; `done`=1 only in cycle 14; `busy`=1 in cycles 10–13.
- `pattern`=8'h0A, `len`=4, `reps`=2, `gap`=3 → frames in cycles k..k+3, k+7..k+10, k+14..k+17; `x_valid`=0 in gap cycles; `done` at k+18.
- `len`=0 → no `x_valid`; `done` in cycle k. Separately, `len`=12 with PAT_W=8 → exactly 8 bits sent.
- Mid-transfer (`len`=8): toggle `start` and change `pattern` → output unchanged. Assert `abort` at bit 3 → IDLE next cycle, no `done`. Assert `reset` mid-frame → all outputs 0 next cycle.
- `reps`=1, `gap`=0 → two frames back-to-back with no idle cycle; `done` at k+2·`len`.
- With `SEQ_GEN_PARITY_EN`: `pattern`=8'h07, `len`=3 → `x_out`=1,1,1,1 (parity 1); `pattern`=8'h05, `len`=3 → 1,0,1,0; `done` at k+4.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern generator with repeat and gap.
// Ports: clk, reset (sync, active-high), start, abort, pattern, len, reps,
//   gap in; x_out, x_valid, busy, done out. Option: SEQ_GEN_PARITY_EN
//   appends an even-parity bit after every frame.
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [PAT_W-1:0] pat_reg;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_top;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_reg;
  logic [GAP_W-1:0] gap_cnt;
  logic [LEN_W-1:0] len_c;
  logic             frame_end;

  assign len_c = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;

`ifdef SEQ_GEN_PARITY_EN
  logic             par_ph;
  logic             par_bit;
  logic [PAT_W-1:0] mask;

  // Shifting by PAT_W yields 0, so the subtraction gives all ones.
  assign mask      = (PAT_W'(1) << len_c) - PAT_W'(1);
  assign frame_end = par_ph;
  assign x_out     = (state == SEND) &&
                     (par_ph ? par_bit : pat_reg[idx]);
`else
  assign frame_end = (idx == '0);
  assign x_out     = (state == SEND) && pat_reg[idx];
`endif

  assign x_valid = (state == SEND);
  assign busy    = (state == SEND) || (state == GAP);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pat_reg <= '0;
      idx     <= '0;
      idx_top <= '0;
      rep_cnt <= '0;
      gap_reg <= '0;
      gap_cnt <= '0;
`ifdef SEQ_GEN_PARITY_EN
      par_ph  <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_reg <= pattern;
            rep_cnt <= reps;
            gap_reg <= gap;
            idx     <= IDX_W'(len_c - LEN_W'(1));
            idx_top <= IDX_W'(len_c - LEN_W'(1));
`ifdef SEQ_GEN_PARITY_EN
            par_ph  <= 1'b0;
            par_bit <= ^(pattern & mask);
`endif
            state   <= (len_c == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
          end else if (frame_end) begin
`ifdef SEQ_GEN_PARITY_EN
            par_ph <= 1'b0;
`endif
            if (rep_cnt == '0) begin
              state <= DONE;
            end else begin
              rep_cnt <= rep_cnt - REP_W'(1);
              if (gap_reg != '0) begin
                gap_cnt <= gap_reg;
                state   <= GAP;
              end else begin
                idx <= idx_top;
              end
            end
`ifdef SEQ_GEN_PARITY_EN
          end else if (idx == '0) begin
            par_ph <= 1'b1;
`endif
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else if (gap_cnt == GAP_W'(1)) begin
            idx   <= idx_top;
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
